restoring_divider: RTL and testbench
====================================

Name: restoring_divider

Overview:
- Unsigned sequential N-bit divider: Quotient = Dividend / Divisor, Remainder = Dividend % Divisor, using restoring shift-subtract, one bit per 2-cycle iteration.
- Inverse companion of the lab's shift-add multiplier; driven by the same board controls (Run, ClearA_LoadB, switches) and drives the same hex-display path.
- Contains its own control FSM and datapath.

Parameters:
- N, 8, operand/result width in bits (N >= 2).
- CNT_W, $clog2(N), iteration counter width.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-low; clears all state immediately.
- Run  in  1  active-low start button, level-sampled.
- ClearA_LoadB  in  1  active-high; in IDLE, loads the divisor from Din.
- Din  in  N  switch input; divisor on load, dividend on start.
- Quotient  out  N  quotient register (working Q register while busy).
- Remainder  out  N  low N bits of the partial-remainder register.
- Div_By_Zero  out  1  set when a start occurred with divisor == 0.
- Busy  out  1  high in SHIFT/SUB states.
- Done  out  1  high in DONE state.

Behaviour:
- Reset low (any time, including mid-division): state=IDLE; B, Q, R, count, Div_By_Zero = 0; all outputs 0. No other reset source.
- Registers: B (N bits, divisor); Q (N bits); R (N+1 bits, partial remainder); count (CNT_W bits).
- States: IDLE, SHIFT, SUB, DONE.
- IDLE:
  - ClearA_LoadB=1: B<=Din, R<=0, Q<=0, Div_By_Zero<=0; stay IDLE. This takes priority over Run.
  - Else Run=0 and B!=0: Q<=Din, R<=0, count<=0, Div_By_Zero<=0; go to SHIFT.
  - Else Run=0 and B==0: Q<=all ones, R<=Din (zero-extended), Div_By_Zero<=1; go to DONE (no iterations).
- SHIFT: {R,Q} <= {R,Q} << 1 (R[0] takes Q[N-1], Q[0]<=0); go to SUB.
- SUB:
  - diff = R - {1'b0,B}, N+2-bit computation.
  - No borrow: R<=diff[N:0], Q[0]<=1. Borrow: R unchanged (restore), Q[0] stays 0.
  - count==N-1: go to DONE. Else count<=count+1, go to SHIFT.
- DONE: hold Q, R, B, and Div_By_Zero. Go to IDLE only when Run=1 (button released). Holding Run low never retriggers.
- Latency (B!=0): 2N cycles of Busy. Done rises on the (2N+1)th rising edge after the edge that sampled Run low (edge 17 for N=8). Divide-by-zero: Done rises on the very next edge.
- Signals ignored while in SHIFT/SUB: ClearA_LoadB, Din, and Run.
- B persists across divisions until reloaded or reset, so repeated Run presses divide new dividends by the same divisor.
- Outputs are registers or decoded from state only; no combinational path from inputs to outputs.
- R never exceeds B-1 after SUB, so R[N] is 0 in DONE; Remainder = R[N-1:0].

Decomposition:
- Package div_pkg holds the state enum typedef (div_state_t: IDLE, SHIFT, SUB, DONE) and the default width constant DIV_N=8.
- Sub-module div_control: FSM plus count, producing ld_b, ld_q, shift_en, sub_en, dz_set. Top restoring_divider holds B/Q/R and the subtractor. This mirrors the multiplier's control/datapath split.

Test Plan:
- Reset low; load B=7 (ClearA_LoadB=1, Din=7); Din=100, Run=0 for 1 cycle -> Busy for 16 cycles, Done on edge 17, Quotient=14, Remainder=2, Div_By_Zero=0.
- B=1, dividend 255 -> Q=255, R=0. B=16, dividend 255 -> Q=15, R=15. B=250, dividend 200 -> Q=0, R=200. B=255, dividend 255 -> Q=1, R=0.
- Load B=0; dividend 37, Run low -> Done next edge, Quotient=8'hFF, Remainder=37, Div_By_Zero=1, Busy never high.
- Hold Run low through completion for 10 extra cycles -> stays DONE with results stable. Release Run -> IDLE next edge. Press again with Din=50, B still 7 -> Q=7, R=1.
- Start 100/7; assert Reset low asynchronously between edges at iteration 3 -> all outputs 0 before the next edge, state IDLE, B=0 afterwards.
- In IDLE, drive ClearA_LoadB=1 and Run=0 together with Din=9 -> B=9, no start (Busy stays 0). Toggle ClearA_LoadB with Din=3 mid-division -> result still uses B=9.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider.
//   div_state_t : control FSM state encoding
//   DIV_N       : default operand/result width
package div_pkg;

    localparam int DIV_N = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SUB   = 2'd2,
        DONE  = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_control.sv
// Control FSM for the restoring divider.
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   run                : active-low start (level sampled)
//   clr_ld_b           : load divisor request (IDLE only, beats run)
//   b_zero             : current divisor is zero
//   ld_b, ld_q, dz_set : one-cycle datapath load strobes from IDLE
//   shift_en, sub_en   : iteration step strobes
//   busy, done         : decoded state outputs
module div_control
    import div_pkg::*;
#(
    parameter int N     = DIV_N,
    parameter int CNT_W = $clog2(N)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr_ld_b,
    input  logic b_zero,
    output logic ld_b,
    output logic ld_q,
    output logic dz_set,
    output logic shift_en,
    output logic sub_en,
    output logic busy,
    output logic done
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ld_b     = 1'b0;
        ld_q     = 1'b0;
        dz_set   = 1'b0;
        shift_en = 1'b0;
        sub_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_ld_b) begin
                    ld_b = 1'b1;
                end else if (!run) begin
                    if (b_zero) begin
                        // No iterations: results are fixed, go straight to DONE.
                        dz_set  = 1'b1;
                        state_d = DONE;
                    end else begin
                        ld_q    = 1'b1;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                state_d  = SUB;
            end
            SUB: begin
                sub_en = 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = SHIFT;
                end
            end
            DONE: begin
                // Only a released button returns to IDLE, so a held press
                // cannot start a second division.
                if (run) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == SHIFT) || (state_q == SUB);
    assign done = (state_q == DONE);

endmodule

// File: rtl/restoring_divider.sv
// Unsigned sequential restoring divider, one quotient bit per SHIFT/SUB pair.
// Ports:
//   Clk, Reset   : clock, async active-low reset
//   Run          : active-low start, Din is the dividend
//   ClearA_LoadB : in IDLE, load divisor from Din
//   Din          : switch input
//   Quotient     : Q register (working value while busy)
//   Remainder    : low N bits of partial remainder
//   Div_By_Zero  : last start found divisor == 0
//   Busy, Done   : SHIFT/SUB and DONE state indicators
module restoring_divider
    import div_pkg::*;
#(
    parameter int N     = DIV_N,
    parameter int CNT_W = $clog2(N)
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Run,
    input  logic         ClearA_LoadB,
    input  logic [N-1:0] Din,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         Div_By_Zero,
    output logic         Busy,
    output logic         Done
);

    logic [N-1:0] b_q, b_d;
    logic [N-1:0] q_q, q_d;
    logic [N:0]   r_q, r_d;
    logic         dz_q, dz_d;
    logic [N+1:0] diff;
    logic         ld_b, ld_q, dz_set, shift_en, sub_en;

    div_control #(.N(N), .CNT_W(CNT_W)) u_ctrl (
        .clk      (Clk),
        .rst_n    (Reset),
        .run      (Run),
        .clr_ld_b (ClearA_LoadB),
        .b_zero   (b_q == '0),
        .ld_b     (ld_b),
        .ld_q     (ld_q),
        .dz_set   (dz_set),
        .shift_en (shift_en),
        .sub_en   (sub_en),
        .busy     (Busy),
        .done     (Done)
    );

    // One extra bit so the MSB is a clean borrow flag.
    assign diff = {1'b0, r_q} - {2'b00, b_q};

    always_comb begin
        b_d  = b_q;
        q_d  = q_q;
        r_d  = r_q;
        dz_d = dz_q;
        if (ld_b) begin
            b_d  = Din;
            q_d  = '0;
            r_d  = '0;
            dz_d = 1'b0;
        end
        if (ld_q) begin
            q_d  = Din;
            r_d  = '0;
            dz_d = 1'b0;
        end
        if (dz_set) begin
            q_d  = '1;
            r_d  = {1'b0, Din};
            dz_d = 1'b1;
        end
        if (shift_en) begin
            {r_d, q_d} = {r_q, q_q} << 1;
        end
        // On borrow R is simply kept, which is the "restore" step.
        if (sub_en && !diff[N+1]) begin
            r_d    = diff[N:0];
            q_d[0] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            b_q  <= '0;
            q_q  <= '0;
            r_q  <= '0;
            dz_q <= 1'b0;
        end else begin
            b_q  <= b_d;
            q_q  <= q_d;
            r_q  <= r_d;
            dz_q <= dz_d;
        end
    end

    assign Quotient    = q_q;
    assign Remainder   = r_q[N-1:0];
    assign Div_By_Zero = dz_q;

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         run = 1'b1;
    logic         clr_ld_b = 1'b0;
    logic [N-1:0] din = '0;
    logic [N-1:0] quo, rem;
    logic         dz, busy, done;

    int passes = 0;
    int total  = 0;
    int mb     = 0;   // model of the divisor register

    restoring_divider #(.N(N)) dut (
        .Clk          (clk),
        .Reset        (rst_n),
        .Run          (run),
        .ClearA_LoadB (clr_ld_b),
        .Din          (din),
        .Quotient     (quo),
        .Remainder    (rem),
        .Div_By_Zero  (dz),
        .Busy         (busy),
        .Done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic load_b(input int b);
        @(negedge clk);
        clr_ld_b = 1'b1;
        din      = N'(b);
        @(negedge clk);
        clr_ld_b = 1'b0;
        mb       = b;
    endtask

    // Start a division with Run held low until Done; optionally wiggle the
    // ignored inputs while busy. Releases Run afterwards and checks IDLE.
    task automatic run_div(input int d, input bit wiggle, input int hold);
        int n = 0, nbusy = 0, eq, er, edz, exp_n;
        if (mb == 0) begin
            eq = (1 << N) - 1; er = d; edz = 1; exp_n = 1;
        end else begin
            eq = d / mb; er = d % mb; edz = 0; exp_n = 2 * N + 1;
        end
        @(negedge clk);
        din = N'(d);
        run = 1'b0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            if (busy) nbusy++;
            if (wiggle && busy) begin
                clr_ld_b = 1'b1;
                din      = 8'd3;
            end
        end
        clr_ld_b = 1'b0;
        check($sformatf("edges_to_done %0d/%0d", d, mb), n, exp_n);
        check("busy_cycles", nbusy, exp_n - 1);
        check($sformatf("quotient %0d/%0d", d, mb), quo, eq);
        check($sformatf("remainder %0d/%0d", d, mb), rem, er);
        check("div_by_zero", dz, edz);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_done", {done, busy, quo, rem}, {1'b1, 1'b0, N'(eq), N'(er)});
        end
        run = 1'b1;
        @(negedge clk);
        check("back_to_idle", {done, busy}, 2'b00);
        check("idle_keeps_q", quo, eq);
    endtask

    initial begin
        // Reset state
        #12;
        check("reset_outputs", {quo, rem, dz, busy, done}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        load_b(7);    run_div(100, 0, 10);
        run_div(50, 0, 0);
        load_b(1);    run_div(255, 0, 0);
        load_b(16);   run_div(255, 0, 0);
        load_b(250);  run_div(200, 0, 0);
        load_b(255);  run_div(255, 0, 0);
        load_b(0);    run_div(37, 0, 0);

        // Async reset mid-division (during iteration 3)
        load_b(7);
        @(negedge clk);
        din = 8'd100;
        run = 1'b0;
        repeat (6) @(negedge clk);
        run = 1'b1;
        check("busy_before_reset", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {quo, rem, dz, busy, done}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        mb    = 0;
        // B was cleared: a start now takes the divide-by-zero path.
        run_div(37, 0, 0);

        // Load and Run together: load wins, no start
        @(negedge clk);
        clr_ld_b = 1'b1;
        run      = 1'b0;
        din      = 8'd9;
        @(negedge clk);
        check("load_priority", {busy, done}, 2'b00);
        clr_ld_b = 1'b0;
        run      = 1'b1;
        mb       = 9;
        @(negedge clk);
        check("still_idle", {busy, done}, 2'b00);
        run_div(50, 1, 0);

        // Random operands, occasional zero divisor
        for (int i = 0; i < 20; i++) begin
            int b;
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
            load_b(b);
            run_div($urandom_range(0, 255), $urandom_range(0, 1), 0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
